// File: rtl/fp_add_ctrl.sv
// fp_add_ctrl: sequencer for the 10-bit floating-point adder datapath.
// Walks align -> add -> normalize -> round and reports done/ovf/unf/zero.
// Optional feature macro: FP_ADD_CTRL_RENORM_EN (one re-normalize pass after
// a rounding carry). When it is undefined, a rounding carry reports ovf instead.
module fp_add_ctrl #(
  parameter int SIG_W = 6,
  parameter int EXP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [EXP_W:0]   exp_diff,
  input  logic [EXP_W-1:0] big_exp,
  input  logic [SIG_W:0]   sum_sig,
  input  logic [SIG_W:0]   rnd_sig,
  output logic             busy,
  output logic             done,
  output logic             sel_x_big,
  output logic             align_en,
  output logic [EXP_W-1:0] align_shift,
  output logic             norm_r_en,
  output logic             norm_l_en,
  output logic [EXP_W-1:0] norm_shift,
  output logic             exp_inc_en,
  output logic             exp_dec_en,
  output logic [EXP_W-1:0] exp_step,
  output logic             sel_fb,
  output logic             round_en,
  output logic             res_zero,
  output logic             ovf,
  output logic             unf
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_CHECK, S_DONE
  } state_t;

  localparam logic [EXP_W:0] E_ONE   = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] E_MAX   = (EXP_W+1)'((1 << EXP_W) - 1);
  localparam logic [EXP_W:0] A_CLAMP = (EXP_W+1)'(SIG_W + 1);

  state_t           state_q, state_d;
  logic [EXP_W:0]   e_q, e_d;
  logic             renorm_q, renorm_d;
  logic [2:0]       exit_q, exit_d;       // {zero, ovf, unf} found in NORM
  logic             busy_q, busy_d, done_q, done_d;
  logic             sel_x_big_q, sel_x_big_d, align_en_q, align_en_d;
  logic [EXP_W-1:0] align_shift_q, align_shift_d;
  logic             norm_r_en_q, norm_r_en_d, norm_l_en_q, norm_l_en_d;
  logic [EXP_W-1:0] norm_shift_q, norm_shift_d;
  logic             exp_inc_en_q, exp_inc_en_d, exp_dec_en_q, exp_dec_en_d;
  logic [EXP_W-1:0] exp_step_q, exp_step_d;
  logic             sel_fb_q, sel_fb_d, round_en_q, round_en_d;
  logic             res_zero_q, res_zero_d, ovf_q, ovf_d, unf_q, unf_d;

  logic             go_norm;
  logic [SIG_W:0]   norm_val;
  logic [EXP_W:0]   e_base, mag, lz_e;
  int unsigned      msb;

  // Next state plus next output values; outputs are registered so each
  // state's enables are computed on the edge that enters that state.
  always_comb begin
    state_d       = state_q;
    e_d           = e_q;
    renorm_d      = renorm_q;
    exit_d        = exit_q;
    sel_x_big_d   = sel_x_big_q;
    sel_fb_d      = sel_fb_q;
    align_en_d    = 1'b0;
    align_shift_d = '0;
    norm_r_en_d   = 1'b0;
    norm_l_en_d   = 1'b0;
    norm_shift_d  = '0;
    exp_inc_en_d  = 1'b0;
    exp_dec_en_d  = 1'b0;
    exp_step_d    = '0;
    round_en_d    = 1'b0;
    res_zero_d    = 1'b0;
    ovf_d         = 1'b0;
    unf_d         = 1'b0;
    go_norm       = 1'b0;
    msb           = 0;
    lz_e          = '0;
    mag           = exp_diff[EXP_W] ? (~exp_diff + E_ONE) : exp_diff;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_ALIGN;
          sel_x_big_d   = ~exp_diff[EXP_W];
          align_en_d    = 1'b1;
          align_shift_d = (mag > A_CLAMP) ? A_CLAMP[EXP_W-1:0] : mag[EXP_W-1:0];
          renorm_d      = 1'b0;
          sel_fb_d      = 1'b0;
          exit_d        = '0;
        end
      end
      S_ALIGN: state_d = S_ADD;
      S_ADD:   go_norm = 1'b1;
      S_NORM: begin
        if (|exit_q) begin
          state_d                     = S_DONE;
          {res_zero_d, ovf_d, unf_d}  = exit_q;
        end else begin
          state_d    = S_ROUND;
          round_en_d = 1'b1;
        end
      end
      S_ROUND: state_d = S_CHECK;
      S_CHECK: begin
`ifdef FP_ADD_CTRL_RENORM_EN
        if (rnd_sig[SIG_W] && !renorm_q) begin
          renorm_d = 1'b1;
          sel_fb_d = 1'b1;
          go_norm  = 1'b1;
        end else begin
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
        ovf_d   = rnd_sig[SIG_W];
`endif
      end
      S_DONE: begin
        state_d     = S_IDLE;
        sel_x_big_d = 1'b0;
        sel_fb_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // The renorm pass normalizes the rounding result from the tracked exponent.
    norm_val = sel_fb_d ? rnd_sig : sum_sig;
    e_base   = sel_fb_d ? e_q : {1'b0, big_exp};
    for (int unsigned i = 0; i < SIG_W; i++) begin
      if (norm_val[i]) msb = i;
    end
    lz_e = (EXP_W+1)'(SIG_W - 1 - msb);

    if (go_norm) begin
      state_d = S_NORM;
      exit_d  = '0;
      if (norm_val == '0) begin
        exit_d[2] = 1'b1;
      end else if (norm_val[SIG_W]) begin
        norm_r_en_d  = 1'b1;
        norm_shift_d = E_ONE[EXP_W-1:0];
        exp_inc_en_d = 1'b1;
        exp_step_d   = E_ONE[EXP_W-1:0];
        if (e_base == E_MAX) exit_d[1] = 1'b1;
        else                 e_d = e_base + E_ONE;
      end else if (norm_val[SIG_W-1]) begin
        e_d = e_base;
      end else begin
        norm_l_en_d  = 1'b1;
        norm_shift_d = lz_e[EXP_W-1:0];
        exp_dec_en_d = 1'b1;
        exp_step_d   = lz_e[EXP_W-1:0];
        if (e_base <= lz_e) exit_d[0] = 1'b1;
        else                e_d = e_base - lz_e;
      end
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, exponent tracker and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      e_q           <= '0;
      renorm_q      <= 1'b0;
      exit_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sel_x_big_q   <= 1'b0;
      align_en_q    <= 1'b0;
      align_shift_q <= '0;
      norm_r_en_q   <= 1'b0;
      norm_l_en_q   <= 1'b0;
      norm_shift_q  <= '0;
      exp_inc_en_q  <= 1'b0;
      exp_dec_en_q  <= 1'b0;
      exp_step_q    <= '0;
      sel_fb_q      <= 1'b0;
      round_en_q    <= 1'b0;
      res_zero_q    <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      e_q           <= e_d;
      renorm_q      <= renorm_d;
      exit_q        <= exit_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      sel_x_big_q   <= sel_x_big_d;
      align_en_q    <= align_en_d;
      align_shift_q <= align_shift_d;
      norm_r_en_q   <= norm_r_en_d;
      norm_l_en_q   <= norm_l_en_d;
      norm_shift_q  <= norm_shift_d;
      exp_inc_en_q  <= exp_inc_en_d;
      exp_dec_en_q  <= exp_dec_en_d;
      exp_step_q    <= exp_step_d;
      sel_fb_q      <= sel_fb_d;
      round_en_q    <= round_en_d;
      res_zero_q    <= res_zero_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sel_x_big   = sel_x_big_q;
  assign align_en    = align_en_q;
  assign align_shift = align_shift_q;
  assign norm_r_en   = norm_r_en_q;
  assign norm_l_en   = norm_l_en_q;
  assign norm_shift  = norm_shift_q;
  assign exp_inc_en  = exp_inc_en_q;
  assign exp_dec_en  = exp_dec_en_q;
  assign exp_step    = exp_step_q;
  assign sel_fb      = sel_fb_q;
  assign round_en    = round_en_q;
  assign res_zero    = res_zero_q;
  assign ovf         = ovf_q;
  assign unf         = unf_q;

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Testbench for fp_add_ctrl: directed and random operations compared cycle
// by cycle against a transaction-level model of the adder sequencing rules.
module tb_fp_add_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [4:0] exp_diff;
  logic [3:0] big_exp;
  logic [6:0] sum_sig, rnd_sig;
  logic       busy, done, sel_x_big, align_en, norm_r_en, norm_l_en;
  logic       exp_inc_en, exp_dec_en, sel_fb, round_en, res_zero, ovf, unf;
  logic [3:0] align_shift, norm_shift, exp_step;

  always #5 clk = ~clk;

  fp_add_ctrl #(.SIG_W(6), .EXP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .exp_diff(exp_diff),
    .big_exp(big_exp), .sum_sig(sum_sig), .rnd_sig(rnd_sig),
    .busy(busy), .done(done), .sel_x_big(sel_x_big), .align_en(align_en),
    .align_shift(align_shift), .norm_r_en(norm_r_en), .norm_l_en(norm_l_en),
    .norm_shift(norm_shift), .exp_inc_en(exp_inc_en), .exp_dec_en(exp_dec_en),
    .exp_step(exp_step), .sel_fb(sel_fb), .round_en(round_en),
    .res_zero(res_zero), .ovf(ovf), .unf(unf)
  );

  typedef struct packed {
    logic       busy, done, sel_x_big, align_en;
    logic [3:0] align_shift;
    logic       norm_r_en, norm_l_en;
    logic [3:0] norm_shift;
    logic       exp_inc_en, exp_dec_en;
    logic [3:0] exp_step;
    logic       sel_fb, round_en, res_zero, ovf, unf;
  } ovec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  ovec_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic ovec_t dut_vec();
    ovec_t v;
    v.busy = busy; v.done = done; v.sel_x_big = sel_x_big; v.align_en = align_en;
    v.align_shift = align_shift; v.norm_r_en = norm_r_en; v.norm_l_en = norm_l_en;
    v.norm_shift = norm_shift; v.exp_inc_en = exp_inc_en; v.exp_dec_en = exp_dec_en;
    v.exp_step = exp_step; v.sel_fb = sel_fb; v.round_en = round_en;
    v.res_zero = res_zero; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  // Expected output vector for every cycle from ALIGN through the done cycle.
  task automatic build_model(input logic [4:0] ed, input logic [3:0] be,
                             input logic [6:0] ss, input logic [6:0] rs);
    ovec_t v;
    int d, mag, e, val, msb, lz;
    bit xbig, fb, renormed, zf, of, uf;
    exp_q.delete();
    d    = ed[4] ? int'(ed) - 32 : int'(ed);
    mag  = (d < 0) ? -d : d;
    xbig = (d >= 0);
    v = '0; v.busy = 1; v.sel_x_big = xbig; v.align_en = 1;
    v.align_shift = 4'((mag > 7) ? 7 : mag);
    exp_q.push_back(v);
    v = '0; v.busy = 1; v.sel_x_big = xbig;
    exp_q.push_back(v);
    e = int'(be); val = int'(ss); fb = 0; renormed = 0;
    forever begin
      zf = 0; of = 0; uf = 0;
      v = '0; v.busy = 1; v.sel_x_big = xbig; v.sel_fb = fb;
      if (val == 0) begin
        zf = 1;
      end else if (val >= 64) begin
        v.norm_r_en = 1; v.norm_shift = 4'd1; v.exp_inc_en = 1; v.exp_step = 4'd1;
        if (e == 15) of = 1; else e = e + 1;
      end else if (val < 32) begin
        msb = 0;
        while ((val >> (msb + 1)) != 0) msb++;
        lz = 5 - msb;
        v.norm_l_en = 1; v.norm_shift = 4'(lz); v.exp_dec_en = 1; v.exp_step = 4'(lz);
        if (e <= lz) uf = 1; else e = e - lz;
      end
      exp_q.push_back(v);
      v = '0; v.busy = 1; v.sel_x_big = xbig; v.sel_fb = fb;
      if (zf || of || uf) begin
        v.done = 1; v.res_zero = zf; v.ovf = of; v.unf = uf;
        exp_q.push_back(v);
        return;
      end
      v.round_en = 1;
      exp_q.push_back(v);
      v.round_en = 0;
      exp_q.push_back(v);
`ifdef FP_ADD_CTRL_RENORM_EN
      if (rs >= 7'd64 && !renormed) begin
        renormed = 1; fb = 1; val = int'(rs);
        continue;
      end
      v.done = 1;
`else
      v.done = 1; v.ovf = (rs >= 7'd64);
`endif
      exp_q.push_back(v);
      return;
    end
  endtask

  // One operation; abort_at > 0 asserts reset in that cycle of the operation.
  task automatic run_op(input string name, input logic [4:0] ed, input logic [3:0] be,
                        input logic [6:0] ss, input logic [6:0] rs, input int abort_at);
    build_model(ed, be, ss, rs);
    @(negedge clk);
    exp_diff = ed; big_exp = be; sum_sig = ss; rnd_sig = rs; start = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      check($sformatf("%s cyc%0d", name, k + 1), 32'(dut_vec()), 32'(exp_q[k]));
      start = 1'($urandom_range(0, 1));
      if (abort_at == k + 1) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check($sformatf("%s after reset", name), 32'(dut_vec()), 32'd0);
        @(negedge clk);
        check($sformatf("%s no done", name), 32'(dut_vec()), 32'd0);
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s idle", name), 32'(dut_vec()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; exp_diff = '0; big_exp = '0; sum_sig = '0; rnd_sig = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", 32'(dut_vec()), 32'd0);
    reset = 1'b0;

    run_op("plain",      5'd2,      4'd7,  7'h30, 7'h30, 0);
    run_op("ralign",     5'b10111,  4'd7,  7'h48, 7'h24, 0);
    run_op("lz3",        5'd0,      4'd6,  7'h04, 7'h20, 0);
    run_op("unf",        5'd1,      4'd3,  7'h04, 7'h20, 0);
    run_op("rcarry",     5'd3,      4'd8,  7'h3F, 7'h40, 0);
    run_op("ovf",        5'd31,     4'd15, 7'h50, 7'h28, 0);
    run_op("zero",       5'd4,      4'd9,  7'h00, 7'h00, 0);
    run_op("min16",      5'b10000,  4'd5,  7'h21, 7'h21, 0);
    run_op("renorm_ovf", 5'd1,      4'd15, 7'h20, 7'h41, 0);
    run_op("abort",      5'd2,      4'd7,  7'h30, 7'h30, 4);

    for (int n = 0; n < 60; n++) begin
      run_op($sformatf("rnd%0d", n), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
             7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_ctrl.md
# fp_add_ctrl

Multi-cycle sequencer for the 10-bit floating-point adder datapath: small ALU, operand muxes, alignment shifter, big ALU, normalize shifter, exponent incrementer/decrementer and rounding unit. On a `start` pulse it walks the datapath through align, add, normalize and round. When a rounding carry occurs it re-normalizes once. It then reports completion plus overflow, underflow and zero status. It replaces hard-wired per-stage enables with one FSM owning every select, shift amount and step.

## Interface
Parameters:
- `SIG_W`, 6: significand width including the hidden bit. The adder sum is `SIG_W+1` bits.
- `EXP_W`, 4: exponent width. Exponent 0 is reserved for a zero result.

Ports:
- `clk`  in  1  the single clock; everything is sampled on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  operation request; sampled only in IDLE.
- `exp_diff`  in  5  two's-complement x_exp − y_exp from the small ALU.
- `big_exp`  in  4  exponent of the larger operand, taken from the exponent mux.
- `sum_sig`  in  7  big-ALU magnitude result; bit 6 is the carry.
- `rnd_sig`  in  7  rounding-unit significand; bit 6 is the rounding carry.
- `busy`  out  1  high from the cycle after `start` is accepted through DONE.
- `done`  out  1  one-cycle completion pulse.
- `sel_x_big`  out  1  1 means x is the large operand (drives muxes 1–3).
- `align_en`  out  1  alignment shifter enable.
- `align_shift`  out  4  right-shift amount applied to the small significand.
- `norm_r_en`, `norm_l_en`  out  1 each  enables for the normalize shifter.
- `norm_shift`  out  4  shift amount for the normalize shifter.
- `exp_inc_en`, `exp_dec_en`  out  1 each  exponent step enables.
- `exp_step`  out  4  exponent step amount.
- `sel_fb`  out  1  selects rounding feedback in muxes 4 and 5.
- `round_en`  out  1  rounding unit enable.
- `res_zero`, `ovf`, `unf`  out  1 each  status flags, valid only while `done` is high.

## Operation
- Reset value of every output is 0. Reset puts the FSM in IDLE and clears the exponent tracker and the renorm flag.
- **IDLE**: when `start` is high, latch `exp_diff` and go to ALIGN.
- **ALIGN** (1 cycle):
  - `sel_x_big` = ~`exp_diff[4]`. A difference of 0 selects x.
  - `align_shift` = min(|exp_diff|, 7).
  - `align_en` = 1.
- **ADD** (1 cycle): all enables are low. Latch `big_exp` into the 5-bit tracker `e`.
- **NORM** (1 cycle), driven by the sampled `sum_sig`, or by `rnd_sig` when `sel_fb` = 1:
  - Value == 0: set `res_zero` and go to DONE.
  - Bit 6 set: `norm_r_en` = 1, `norm_shift` = 1, `exp_inc_en` = 1, `exp_step` = 1. If `e` == 15, set `ovf` and go to DONE. Otherwise `e` = `e` + 1.
  - Bit 5 set (and bit 6 clear): no shift.
  - Otherwise, with lz = 5 − index of the MS one: `norm_l_en` = 1, `norm_shift` = lz, `exp_dec_en` = 1, `exp_step` = lz. If `e` ≤ lz, set `unf` and go to DONE. Otherwise `e` = `e` − lz.
- **ROUND** (1 cycle): `round_en` = 1.
- **CHECK**:
  - If `rnd_sig[6]` = 1 and no renorm has occurred: set `sel_fb` = 1, mark renorm and go to NORM.
  - Otherwise go to DONE.
- **DONE**: `done` = 1 and flags are valid. Flags and `sel_fb` clear on the next cycle. Return to IDLE.
- `start` while `busy` is ignored; there is no queueing.
- At most one renorm pass per operation. A second rounding carry is impossible by construction and is not checked.
- Reset mid-operation aborts the operation: no `done` is produced and all outputs read 0 on the next cycle.

## Timing
- `start` accepted at edge 0. Enables are registered outputs of the current state.
- ALIGN is cycle 1, ADD cycle 2, NORM cycle 3, ROUND cycle 4, CHECK cycle 5, `done` at cycle 6.
- Renorm path: `done` at cycle 9.
- Zero, overflow or underflow detected in NORM: `done` at cycle 4, or at cycle 7 when detected in the renorm NORM.
- A new `start` is accepted at the earliest in the cycle after `done` (IDLE).

## Configuration
- `FP_ADD_CTRL_RENORM_EN` defined: behaves as above.
- Undefined: CHECK always goes to DONE, `sel_fb` stays 0, and a rounding carry sets `ovf` in the `done` cycle. Latency is fixed at 6 (or 4 for an early exit).

## Test plan
- `exp_diff` = +2, `big_exp` = 7, `sum_sig` = 0x30, `rnd_sig` = 0x30 -> ALIGN shows `sel_x_big` = 1 and `align_shift` = 2. NORM has no shift and no step. `done` at cycle 6 with all flags 0.
- `exp_diff` = −9 (5'b10111), `sum_sig` = 0x48 -> `sel_x_big` = 0 and `align_shift` = 7. NORM asserts `norm_r_en` with shift 1 and `exp_inc_en` with step 1.
- `big_exp` = 6, `sum_sig` = 0x04 -> lz = 3: `norm_l_en` shift 3 and `exp_dec_en` step 3. With `big_exp` = 3 instead: `unf` = 1 and `done` at cycle 4.
- `sum_sig` = 0x3F, then `rnd_sig` = 0x40 in CHECK -> `sel_fb` = 1, second NORM right-shifts by 1, `done` at cycle 9. With the macro undefined: `done` at cycle 6 with `ovf` = 1.
- `big_exp` = 15, `sum_sig` = 0x50 -> `ovf` = 1 and `done` at cycle 4. Also `sum_sig` = 0 -> `res_zero` = 1 and `done` at cycle 4.
- Assert `reset` in ROUND -> the next cycle shows all outputs 0 and no `done`. A `start` pulse during `busy` is ignored.
